zion_clr_skid_reg: RTL and testbench
====================================

# zion_clr_skid_reg

Two-entry valid/ready register slice with a synchronous clear and a configurable idle value. It is the handshaked counterpart of the library's clearable reset-configurable DFF. The upstream side accepts beats through a registered ready, and the downstream side holds each beat until it is taken. It sits between a producer and a consumer to cut the valid, data and ready timing paths without losing throughput; the downstream side is the receiving end of the same stream.

## Interface
- WIDTH_DAT, 32, payload width in bits
- INI_DATA, 0, value driven on oDat whenever no beat is held; loaded by reset and by clear
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  reset, synchronous and active-high
- iClr  input  1  synchronous clear; discards all held beats
- iVld  input  1  upstream beat valid
- oRdy  output  1  upstream ready
- iDat  input  WIDTH_DAT  upstream payload
- oVld  output  1  downstream beat valid
- iRdy  input  1  downstream ready
- oDat  output  WIDTH_DAT  downstream payload
- oCnt  output  2  number of beats held (0..2)

## Operation
- **Storage:** a main register drives oVld and oDat. A skid register holds one extra beat.
- **States:**
  - EMPTY: oCnt=0.
  - ONE: main valid, oCnt=1.
  - FULL: main and skid both valid, oCnt=2.
- **Transfer definitions:**
  - In-transfer: iVld & oRdy.
  - Out-transfer: oVld & iRdy.
- **oRdy:** equals rdy_q & ~rst & ~iClr. rdy_q is registered and equals "state will not be FULL".
- **EMPTY:**
  - in → ONE; main ← iDat.
  - no in → stay in EMPTY.
- **ONE:**
  - in & out → ONE; main ← iDat.
  - in & ~out → FULL; skid ← iDat.
  - out & ~in → EMPTY; main ← INI_DATA.
  - neither → stay in ONE.
- **FULL** (oRdy=0, so no in-transfer is possible):
  - out → ONE; main ← skid.
  - no out → stay in FULL.
- **Data ordering:** beats leave strictly in arrival order. No beat is duplicated or dropped, except by clear or reset.
- **Clear / reset:**
  - When rst=1 or iClr=1 at an edge, the next state is EMPTY, main and skid ← INI_DATA, and rdy_q ← 1.
  - rst and iClr have identical effect. rst has priority only in name; the result is the same.
  - An out-transfer in a clear or reset cycle completes: the consumer owns that beat. The remaining beat, if any, is discarded.
  - No in-transfer can complete in a clear or reset cycle, because oRdy is gated low.
- **oCnt:** equals the state encoding directly (0/1/2). The value 3 never occurs.

## Timing
- **Reset values** (after the first edge with rst=1):
  - oVld=0, oDat=INI_DATA, oCnt=0.
  - oRdy=0 while rst is high; oRdy=1 in the first cycle with rst=0 and iClr=0.
- **Latency:** a beat accepted at edge N is visible on oVld/oDat from edge N, i.e. one cycle.
- **Throughput:** one beat per cycle sustained while iRdy=1. The state stays in ONE with back-to-back transfers.
- **Entering FULL:** iRdy low for one cycle with an in-transfer → FULL at the next edge, and oRdy=0 from that edge.
- **Leaving FULL:** oRdy returns to 1 at the edge of the first out-transfer.
- **Path isolation:** there is no combinational path iRdy→oRdy or iVld→oVld. oRdy depends combinationally only on rdy_q, rst and iClr.
- **Stability:** oDat and oVld are stable while oVld=1 and iRdy=0.

## Test plan
- **Reset:**
  - Stimulus: INI_DATA=32'h1; rst high for 2 edges with iVld=1, iDat=32'hA5.
  - Required: oRdy=0 throughout reset; then oVld=0, oDat=32'h1, oCnt=0, oRdy=1 in the first free cycle.
- **Streaming:**
  - Stimulus: iRdy=1; iVld=1 with iDat=1,2,3,4 on consecutive cycles.
  - Required: oDat=1,2,3,4 with oVld=1, each one cycle after acceptance; oCnt=1 throughout; oRdy stays 1.
- **Backpressure:**
  - Stimulus: iRdy=0; offer iDat=10,11,12.
  - Required: 10 and 11 are accepted, oCnt=2, and oRdy=0 with 12 held off.
  - Continue: raise iRdy.
  - Required: outputs 10, 11, 12 in order, with no gaps once 12 is accepted.
- **Clear while FULL:**
  - Stimulus: FULL holding 20 and 21, iRdy=0; pulse iClr for 1 cycle with iVld=1, iDat=22.
  - Required: 22 not accepted (oRdy=0); next cycle oCnt=0, oVld=0, oDat=INI_DATA.
- **Clear with simultaneous out-transfer:**
  - Stimulus: FULL holding 30 and 31; iRdy=1 and iClr=1 in the same cycle.
  - Required: 30 is delivered in that cycle; 31 is discarded; next cycle is EMPTY.
- **Reset mid-stream:**
  - Stimulus: random iVld/iRdy/iClr traffic, with rst asserted for 1 cycle.
  - Required: a scoreboard shows in-order delivery with no duplicates; the only drops are beats held at clear or reset edges.

Source files
------------

// File: rtl/zion_clr_skid_reg.sv
// Two-entry valid/ready register slice with synchronous clear and a configurable idle value.
// The main register drives the downstream side; a skid register absorbs the one beat that
// can arrive after the downstream side stalls, so upstream ready can be registered.
module zion_clr_skid_reg #(
  parameter int unsigned          WIDTH_DAT = 32,
  parameter logic [WIDTH_DAT-1:0] INI_DATA  = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 iClr,
  input  logic                 iVld,
  output logic                 oRdy,
  input  logic [WIDTH_DAT-1:0] iDat,
  output logic                 oVld,
  input  logic                 iRdy,
  output logic [WIDTH_DAT-1:0] oDat,
  output logic [1:0]           oCnt
);

  // Encoding doubles as the held-beat count.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH_DAT-1:0] mainDat_q, mainDat_d;
  logic [WIDTH_DAT-1:0] skidDat_q, skidDat_d;
  logic                 rdy_q, rdy_d;
  logic                 inXfer, outXfer;

  // Ready only depends on registered state plus reset/clear gating.
  assign oRdy    = rdy_q & ~rst & ~iClr;
  assign oVld    = (state_q != StEmpty);
  assign oDat    = mainDat_q;
  assign oCnt    = state_q;
  assign inXfer  = iVld & oRdy;
  assign outXfer = oVld & iRdy;

  // Next-state and storage update; clear overrides the normal transitions.
  always_comb begin
    state_d   = state_q;
    mainDat_d = mainDat_q;
    skidDat_d = skidDat_q;
    case (state_q)
      StEmpty: begin
        if (inXfer) begin
          state_d   = StOne;
          mainDat_d = iDat;
        end
      end
      StOne: begin
        if (inXfer && outXfer) begin
          mainDat_d = iDat;
        end else if (inXfer) begin
          state_d   = StFull;
          skidDat_d = iDat;
        end else if (outXfer) begin
          state_d   = StEmpty;
          mainDat_d = INI_DATA;
        end
      end
      StFull: begin
        if (outXfer) begin
          state_d   = StOne;
          mainDat_d = skidDat_q;
        end
      end
      default: begin
        state_d   = StEmpty;
        mainDat_d = INI_DATA;
        skidDat_d = INI_DATA;
      end
    endcase
    // An out-transfer in this cycle still completes; whatever remains is dropped.
    if (iClr) begin
      state_d   = StEmpty;
      mainDat_d = INI_DATA;
      skidDat_d = INI_DATA;
    end
    rdy_d = (state_d != StFull);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StEmpty;
      mainDat_q <= INI_DATA;
      skidDat_q <= INI_DATA;
      rdy_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      mainDat_q <= mainDat_d;
      skidDat_q <= skidDat_d;
      rdy_q     <= rdy_d;
    end
  end

endmodule

// File: tb/tb_zion_clr_skid_reg.sv
// Directed and scoreboard-checked bench for zion_clr_skid_reg.
module tb_zion_clr_skid_reg;

  localparam int unsigned W   = 32;
  localparam logic [W-1:0] INI = 32'h1;

  logic         clk = 1'b0;
  logic         rst, iClr, iVld, iRdy;
  logic         oRdy, oVld;
  logic [W-1:0] iDat, oDat;
  logic [1:0]   oCnt;

  int nChk  = 0;
  int nPass = 0;

  zion_clr_skid_reg #(
    .WIDTH_DAT(W),
    .INI_DATA (INI)
  ) dut (
    .clk (clk),
    .rst (rst),
    .iClr(iClr),
    .iVld(iVld),
    .oRdy(oRdy),
    .iDat(iDat),
    .oVld(oVld),
    .iRdy(iRdy),
    .oDat(oDat),
    .oCnt(oCnt)
  );

  always #5 clk = ~clk;

  // Advance past the next rising edge, then let outputs settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; iClr = 1'b0; iVld = 1'b1; iDat = 32'hA5; iRdy = 1'b0;
    #1;
    nChk++; if (oRdy !== 1'b0) $display("FAIL reset_rdy_pre got %b want 0", oRdy); else nPass++;
    for (int i = 0; i < 2; i++) begin
      tick();
      nChk++;
      if (oRdy !== 1'b0) $display("FAIL reset_rdy_%0d got %b want 0", i, oRdy); else nPass++;
    end
    rst = 1'b0; iVld = 1'b0;
    #1;
    nChk++; if (oVld !== 1'b0) $display("FAIL reset_vld got %b want 0", oVld); else nPass++;
    nChk++; if (oDat !== INI) $display("FAIL reset_dat got %h want %h", oDat, INI); else nPass++;
    nChk++; if (oCnt !== 2'd0) $display("FAIL reset_cnt got %0d want 0", oCnt); else nPass++;
    nChk++; if (oRdy !== 1'b1) $display("FAIL reset_rdy_free got %b want 1", oRdy); else nPass++;
  endtask

  task automatic test_streaming();
    iRdy = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      iVld = 1'b1; iDat = W'(i);
      #1;
      nChk++; if (oRdy !== 1'b1) $display("FAIL stream_rdy_%0d got %b want 1", i, oRdy); else nPass++;
      tick();
      nChk++;
      if (oVld !== 1'b1 || oDat !== W'(i) || oCnt !== 2'd1)
        $display("FAIL stream_out_%0d got vld=%b dat=%0d cnt=%0d want vld=1 dat=%0d cnt=1",
                 i, oVld, oDat, oCnt, i);
      else nPass++;
    end
    iVld = 1'b0;
    tick();
    nChk++;
    if (oCnt !== 2'd0 || oDat !== INI)
      $display("FAIL stream_drain got cnt=%0d dat=%h want cnt=0 dat=%h", oCnt, oDat, INI);
    else nPass++;
  endtask

  task automatic test_backpressure();
    iRdy = 1'b0; iVld = 1'b1; iDat = 32'd10;
    tick();
    nChk++; if (oRdy !== 1'b1) $display("FAIL bp_rdy_one got %b want 1", oRdy); else nPass++;
    iDat = 32'd11;
    tick();
    nChk++;
    if (oCnt !== 2'd2 || oRdy !== 1'b0)
      $display("FAIL bp_full got cnt=%0d rdy=%b want cnt=2 rdy=0", oCnt, oRdy);
    else nPass++;
    iDat = 32'd12;
    tick();
    nChk++;
    if (oCnt !== 2'd2 || oDat !== 32'd10 || oRdy !== 1'b0)
      $display("FAIL bp_hold got cnt=%0d dat=%0d rdy=%b want cnt=2 dat=10 rdy=0", oCnt, oDat, oRdy);
    else nPass++;
    iRdy = 1'b1;
    tick();
    nChk++;
    if (oVld !== 1'b1 || oDat !== 32'd11 || oCnt !== 2'd1 || oRdy !== 1'b1)
      $display("FAIL bp_out11 got vld=%b dat=%0d cnt=%0d rdy=%b want 1/11/1/1",
               oVld, oDat, oCnt, oRdy);
    else nPass++;
    tick();
    nChk++;
    if (oVld !== 1'b1 || oDat !== 32'd12)
      $display("FAIL bp_out12 got vld=%b dat=%0d want vld=1 dat=12", oVld, oDat);
    else nPass++;
    iVld = 1'b0;
    tick();
    nChk++; if (oCnt !== 2'd0) $display("FAIL bp_drain got cnt=%0d want 0", oCnt); else nPass++;
  endtask

  task automatic test_clear_full();
    iRdy = 1'b0; iVld = 1'b1; iDat = 32'd20;
    tick();
    iDat = 32'd21;
    tick();
    iClr = 1'b1; iDat = 32'd22;
    #1;
    nChk++; if (oRdy !== 1'b0) $display("FAIL clrfull_rdy got %b want 0", oRdy); else nPass++;
    tick();
    iClr = 1'b0; iVld = 1'b0;
    #1;
    nChk++;
    if (oCnt !== 2'd0 || oVld !== 1'b0 || oDat !== INI)
      $display("FAIL clrfull_empty got cnt=%0d vld=%b dat=%h want 0/0/%h", oCnt, oVld, oDat, INI);
    else nPass++;
  endtask

  task automatic test_clear_out();
    iRdy = 1'b0; iVld = 1'b1; iDat = 32'd30;
    tick();
    iDat = 32'd31;
    tick();
    iVld = 1'b0; iRdy = 1'b1; iClr = 1'b1;
    #1;
    nChk++;
    if (oVld !== 1'b1 || oDat !== 32'd30)
      $display("FAIL clrout_deliver got vld=%b dat=%0d want vld=1 dat=30", oVld, oDat);
    else nPass++;
    tick();
    iClr = 1'b0;
    #1;
    nChk++;
    if (oCnt !== 2'd0 || oVld !== 1'b0)
      $display("FAIL clrout_empty got cnt=%0d vld=%b want 0/0", oCnt, oVld);
    else nPass++;
    tick();
    nChk++;
    if (oVld !== 1'b0 || oDat !== INI)
      $display("FAIL clrout_no31 got vld=%b dat=%h want vld=0 dat=%h", oVld, oDat, INI);
    else nPass++;
  endtask

  // Queue model of held beats; ready is expected whenever fewer than two are held.
  task automatic test_random();
    logic [W-1:0] q[$];
    logic [W-1:0] nextVal = 32'd100;
    logic [W-1:0] lastOut = 32'd0;
    logic         inTx, outTx, expRdy;
    int           rstCycle = 97;
    for (int c = 0; c < 300; c++) begin
      rst  = (c == rstCycle);
      iClr = ($urandom_range(0, 19) == 0);
      iVld = ($urandom_range(0, 3) != 0);
      iRdy = ($urandom_range(0, 2) != 0);
      iDat = nextVal;
      #1;
      expRdy = (q.size() < 2) && !rst && !iClr;
      nChk++;
      if (oRdy !== expRdy || oCnt !== 2'(q.size()) || oVld !== (q.size() > 0))
        $display("FAIL rand_ctl_%0d got rdy=%b cnt=%0d vld=%b want rdy=%b cnt=%0d vld=%b",
                 c, oRdy, oCnt, oVld, expRdy, q.size(), q.size() > 0);
      else nPass++;
      if (q.size() > 0) begin
        nChk++;
        if (oDat !== q[0]) $display("FAIL rand_dat_%0d got %0d want %0d", c, oDat, q[0]);
        else nPass++;
      end else begin
        nChk++;
        if (oDat !== INI) $display("FAIL rand_idle_%0d got %h want %h", c, oDat, INI);
        else nPass++;
      end
      inTx  = iVld && expRdy;
      outTx = (q.size() > 0) && iRdy;
      if (outTx) begin
        nChk++;
        if (q[0] <= lastOut) $display("FAIL rand_order_%0d got %0d after %0d", c, q[0], lastOut);
        else nPass++;
        lastOut = q[0];
        void'(q.pop_front());
      end
      if (rst || iClr) q.delete();
      else if (inTx) q.push_back(iDat);
      if (inTx) nextVal = nextVal + 1;
      @(posedge clk);
      #1;
    end
    rst = 1'b0; iClr = 1'b0; iVld = 1'b0;
  endtask

  initial begin
    rst = 1'b0; iClr = 1'b0; iVld = 1'b0; iRdy = 1'b0; iDat = '0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_clear_full();
    test_clear_out();
    test_random();
    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end

endmodule
